// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//
// Receives PS/2 keyboard frames from the raw board pins and converts scan-code
// sequences into held-key levels for the character controller.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         synchronous, active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   key_space   1 while Space (29) is held
//   key_left    1 while Left arrow (E0 6B) is held
//   key_right   1 while Right arrow (E0 74) is held
//   scan_code   last correctly received byte
//   scan_valid  one-cycle pulse when scan_code updates
//   frame_err   one-cycle pulse on parity, stop-bit or timeout error
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_space,
   output logic       key_left,
   output logic       key_right,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Odd parity over data + parity bit, and a high stop bit.
   function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
      return (^{d, p}) & s;
   endfunction

   // Stage p0/p1: two-flop synchronizers on the raw pins.
   logic ps2_clk_p0, ps2_clk_p1;
   logic ps2_data_p0, ps2_data_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         ps2_clk_p0 <= 1'b1;
         ps2_clk_p1 <= 1'b1;
      end else begin
         ps2_clk_p0 <= ps2_clk;
         ps2_clk_p1 <= ps2_clk_p0;
      end
   end

   always_ff @(posedge clk) begin
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
   end

   // Stage p2: clock deglitch filter and falling-edge strobe.
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          vld_p2;
   logic          data_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         vld_p2   <= 1'b0;
      end else begin
         vld_p2 <= 1'b0;
         if (ps2_clk_p1 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FLT_LAST) begin
            // FILTER_LEN consecutive samples disagree: accept the new level.
            // A strobe is produced only when the accepted change is 1->0.
            filt_clk <= ps2_clk_p1;
            filt_cnt <= '0;
            vld_p2   <= filt_clk;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // Data sample aligned with the strobe register.
   always_ff @(posedge clk) begin
      data_p2 <= ps2_data_p1;
   end

   // Stage p3: frame FSM, timeout and key decoder (all outputs registered).
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_p3;
   logic          par_p3;
   logic [TW-1:0] tmo_cnt;
   logic          ext;
   logic          brk;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         key_space  <= 1'b0;
         key_left   <= 1'b0;
         key_right  <= 1'b0;
         scan_code  <= '0;
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (vld_p2 || state == IDLE) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if (vld_p2) begin
            case (state)
               IDLE: begin
                  // A high level at a falling edge is not a start bit.
                  if (!data_p2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift_p3 <= {data_p2, shift_p3[7:1]};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_p3 <= data_p2;
                  state  <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_ok(shift_p3, par_p3, data_p2)) begin
                     scan_code  <= shift_p3;
                     scan_valid <= 1'b1;
                     case (shift_p3)
                        8'hE0: ext <= 1'b1;
                        8'hF0: brk <= 1'b1;
                        default: begin
                           if (!ext && shift_p3 == 8'h29) key_space <= !brk;
                           if (ext && shift_p3 == 8'h6B)  key_left  <= !brk;
                           if (ext && shift_p3 == 8'h74)  key_right <= !brk;
                           ext <= 1'b0;
                           brk <= 1'b0;
                        end
                     endcase
                  end else begin
                     // Bad frame: drop any pending prefix, keep key levels.
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            ext       <= 1'b0;
            brk       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Self-checking bench for ps2_key_decoder: drives PS/2 frames on the raw pins
// and compares key levels, scan bytes and error strobes against expectations.
// ----------------------------------------------------------------------------
module tb_ps2_key_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;
   localparam int HALF       = 40;   // half PS/2 bit period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_space, key_left, key_right;
   logic [7:0] scan_code;
   logic       scan_valid, frame_err;

   ps2_key_decoder #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_space  (key_space),
      .key_left   (key_left),
      .key_right  (key_right),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   int         sv_cnt = 0;
   int         fe_cnt = 0;
   int         fe_cyc = 0;
   int         pulse_viol = 0;
   logic [7:0] last_code = 8'h00;
   logic       prev_sv = 1'b0;
   logic       prev_fe = 1'b0;

   always @(negedge clk) begin
      if (scan_valid) begin
         sv_cnt++;
         last_code = scan_code;
      end
      if (frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if ((scan_valid && frame_err) || (scan_valid && prev_sv) || (frame_err && prev_fe))
         pulse_viol++;
      prev_sv = scan_valid;
      prev_fe = frame_err;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: prefix bytes are queued until a resolving byte arrives.
   logic [7:0] pend[$];
   bit m_space = 0, m_left = 0, m_right = 0;

   task automatic model_reset();
      pend.delete();
      m_space = 0; m_left = 0; m_right = 0;
   endtask

   task automatic model_apply(input logic [7:0] b, input bit good);
      bit is_ext, is_brk;
      if (!good) begin
         pend.delete();
         return;
      end
      if (b == 8'hE0 || b == 8'hF0) begin
         pend.push_back(b);
         return;
      end
      is_ext = 0;
      is_brk = 0;
      foreach (pend[i]) begin
         if (pend[i] == 8'hE0) is_ext = 1;
         if (pend[i] == 8'hF0) is_brk = 1;
      end
      if (!is_ext && b == 8'h29) m_space = !is_brk;
      if (is_ext && b == 8'h6B)  m_left  = !is_brk;
      if (is_ext && b == 8'h74)  m_right = !is_brk;
      pend.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int fall_cyc = 0;

   // Drives the first nbits of a frame; glitch_at inserts a 3-cycle low
   // pulse in the high phase preceding that bit's falling edge.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int glitch_at);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         if (i == glitch_at) begin
            idle(20);
            ps2_clk = 1'b0;
            idle(3);
            ps2_clk = 1'b1;
            idle(HALF - 23);
         end else begin
            idle(HALF);
         end
         ps2_clk  = 1'b0;
         fall_cyc = cyc;
         idle(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      idle(20);
   endtask

   task automatic do_frame(input string name, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input int glitch_at);
      int sv0, fe0;
      bit good;
      sv0  = sv_cnt;
      fe0  = fe_cnt;
      good = !bad_par && !bad_stop;
      send_frame(b, bad_par, bad_stop, 11, glitch_at);
      model_apply(b, good);
      check({name, " scan_valid pulses"}, sv_cnt - sv0, int'(good));
      check({name, " frame_err pulses"}, fe_cnt - fe0, int'(!good));
      if (good) check({name, " scan_code"}, last_code, b);
      check({name, " keys"}, {key_space, key_left, key_right}, {m_space, m_left, m_right});
   endtask

   typedef struct {
      logic [7:0] code;
      bit         bad_par;
      bit         bad_stop;
      logic [2:0] keys;   // {space, left, right} after the frame
   } vec_t;

   vec_t tbl[23];
   logic [7:0] pool[10];

   initial begin
      int sv0, fe0, lat;

      tbl[0]  = '{8'h29, 1'b0, 1'b0, 3'b100};
      tbl[1]  = '{8'hF0, 1'b0, 1'b0, 3'b100};
      tbl[2]  = '{8'h29, 1'b0, 1'b0, 3'b000};
      tbl[3]  = '{8'hE0, 1'b0, 1'b0, 3'b000};
      tbl[4]  = '{8'h6B, 1'b0, 1'b0, 3'b010};
      tbl[5]  = '{8'hE0, 1'b0, 1'b0, 3'b010};
      tbl[6]  = '{8'h74, 1'b0, 1'b0, 3'b011};
      tbl[7]  = '{8'h29, 1'b0, 1'b0, 3'b111};
      tbl[8]  = '{8'hE0, 1'b0, 1'b0, 3'b111};
      tbl[9]  = '{8'hF0, 1'b0, 1'b0, 3'b111};
      tbl[10] = '{8'h6B, 1'b0, 1'b0, 3'b101};
      tbl[11] = '{8'hE0, 1'b0, 1'b0, 3'b101};
      tbl[12] = '{8'h74, 1'b0, 1'b0, 3'b101};
      tbl[13] = '{8'h6B, 1'b0, 1'b0, 3'b101};
      tbl[14] = '{8'hE0, 1'b0, 1'b0, 3'b101};
      tbl[15] = '{8'h12, 1'b0, 1'b0, 3'b101};
      tbl[16] = '{8'h6B, 1'b0, 1'b0, 3'b101};
      tbl[17] = '{8'hF0, 1'b0, 1'b0, 3'b101};
      tbl[18] = '{8'h29, 1'b0, 1'b0, 3'b001};
      tbl[19] = '{8'h29, 1'b1, 1'b0, 3'b001};
      tbl[20] = '{8'hF0, 1'b0, 1'b0, 3'b001};
      tbl[21] = '{8'h29, 1'b0, 1'b1, 3'b001};
      tbl[22] = '{8'h29, 1'b0, 1'b0, 3'b101};

      pool = '{8'h29, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12, 8'hE1, 8'hFA, 8'hAA, 8'h00};

      // Reset state.
      idle(5);
      check("reset keys", {key_space, key_left, key_right}, 0);
      check("reset scan_code", scan_code, 0);
      check("reset strobes", {scan_valid, frame_err}, 0);
      rst = 1'b0;
      idle(5);
      check("post-reset keys", {key_space, key_left, key_right}, 0);

      // Table-driven make/break, arrows, extended gating, bad frames.
      for (int i = 0; i < 23; i++) begin
         do_frame($sformatf("vec%0d", i), tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, -1);
         check($sformatf("vec%0d table keys", i), {key_space, key_left, key_right}, tbl[i].keys);
      end

      // Timeout: a pending break prefix is dropped along with the partial frame.
      do_frame("tmo pre F0", 8'hF0, 0, 0, -1);
      do_frame("tmo pre 29", 8'h29, 0, 0, -1);
      do_frame("tmo F0", 8'hF0, 0, 0, -1);
      sv0 = sv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h29, 0, 0, 5, -1);
      for (int k = 0; k < TIMEOUT + 200 && fe_cnt == fe0; k++) idle(1);
      model_apply(8'h00, 0);
      check("timeout frame_err pulses", fe_cnt - fe0, 1);
      check("timeout scan_valid pulses", sv_cnt - sv0, 0);
      lat = fe_cyc - fall_cyc;
      check("timeout latency", (lat >= 2009 && lat <= 2013) ? 2011 : lat, 2011);
      check("timeout keys", {key_space, key_left, key_right}, {m_space, m_left, m_right});
      do_frame("after timeout 29", 8'h29, 0, 0, -1);
      check("after timeout space", key_space, 1);

      // Glitches on ps2_clk in IDLE and in the middle of the data bits.
      sv0 = sv_cnt;
      fe0 = fe_cnt;
      ps2_clk = 1'b0;
      idle(3);
      ps2_clk = 1'b1;
      idle(40);
      check("idle glitch strobes", (sv_cnt - sv0) + (fe_cnt - fe0), 0);
      do_frame("glitch F0", 8'hF0, 0, 0, 4);
      do_frame("glitch 29 brk", 8'h29, 0, 0, 7);
      do_frame("glitch 29 make", 8'h29, 0, 0, 2);

      // Reset mid-frame while Space is held.
      send_frame(8'h29, 0, 0, 4, -1);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      model_reset();
      check("mid reset keys", {key_space, key_left, key_right}, 0);
      check("mid reset scan_code", scan_code, 0);
      check("mid reset strobes", {scan_valid, frame_err}, 0);
      idle(20);
      do_frame("after reset 29", 8'h29, 0, 0, -1);

      // Randomized frames against the reference model.
      for (int i = 0; i < 25; i++) begin
         logic [7:0] b;
         bit bp, bs;
         pool[9] = 8'($urandom_range(0, 255));
         b  = pool[$urandom_range(0, 9)];
         bp = ($urandom_range(0, 9) == 0);
         bs = ($urandom_range(0, 19) == 0);
         do_frame($sformatf("rnd%0d", i), b, bp, bs, -1);
      end

      check("pulse width/exclusivity", pulse_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_bad);
      $fatal(1);
   end

endmodule
